trace_feeder: RTL and testbench

Trace playback stage directly upstream of `cache_top`. Holds a loadable table of (address, op) trace entries and replays them into the cache request port with a valid/ready handshake. Filters malformed ops and keeps issue statistics. Replaces hand-driven per-cycle stimulus with a synthesizable, backpressure-aware source.

---
 rtl/cache_pkg.sv | 16 +
 rtl/trace_ram.sv | 31 +++
 rtl/trace_feeder.sv | 149 ++++++++++++++
 tb/tb_trace_feeder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache request path: op codes and feeder FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;  // ASCII 'R'
    localparam logic [7:0] OP_WRITE = 8'h57;  // ASCII 'W'

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/trace_ram.sv
// Trace table storage: DEPTH x W, one write port, one registered read port, no reset.
// Latency: read data appears the cycle after rd_en; writes visible to a read the next cycle.
// Backpressure: none; the owner gates wr_en/rd_en.
//
// Ports: clk; wr_en/wr_idx/wr_dat write one entry; rd_en/rd_idx/rd_dat registered read.
module trace_ram #(
    parameter int DEPTH = 100,
    parameter int W     = 56
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [W-1:0]             rd_dat
);

    logic [W-1:0] mem [DEPTH];

    // Contents intentionally survive reset so a trace can be replayed after one.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/trace_feeder.sv
// Replays a loadable (address, op) trace into the cache request port, filtering non R/W ops.
// Latency: first req_valid two cycles after start is sampled; 2 cycles per entry at full rate.
// Backpressure: a presented request holds addr/op/valid until req_ready; each stall adds a cycle.
//
// Ports: clk/reset (async active-low); load_* write the table while idle/done;
// trace_len/start launch a replay; cache_addr/cache_op/req_valid/req_ready form the request
// handshake; busy/done report progress; num_* are saturating statistics cleared by start.
module trace_feeder
    import cache_pkg::*;
#(
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 48,
    parameter int OP_W   = 8,
    parameter int CNT_W  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_idx,
    input  logic [ADDR_W-1:0]          load_addr,
    input  logic [OP_W-1:0]            load_op,
    input  logic [$clog2(DEPTH+1)-1:0] trace_len,
    input  logic                       start,
    output logic [ADDR_W-1:0]          cache_addr,
    output logic [OP_W-1:0]            cache_op,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           num_issued,
    output logic [CNT_W-1:0]           num_reads,
    output logic [CNT_W-1:0]           num_writes,
    output logic [CNT_W-1:0]           num_skipped
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + OP_W;

    feeder_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_clamp;
    logic [ENT_W-1:0]  ram_dat;
    logic [ADDR_W-1:0] ent_addr;
    logic [OP_W-1:0]   ent_op;
    logic              idle_like;
    logic              launch;
    logic              op_rd;
    logic              op_wr;
    logic              op_ok;
    logic              hs;
    logic              advance;
    logic              last;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign launch    = idle_like && start;
    assign len_clamp = (trace_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : trace_len;

    assign {ent_addr, ent_op} = ram_dat;
    assign op_rd = (ent_op == OP_W'(OP_READ));
    assign op_wr = (ent_op == OP_W'(OP_WRITE));
    assign op_ok = op_rd || op_wr;

    // Handshake is derived from state and op directly rather than from req_valid,
    // so the next-state logic below has no self-referencing path.
    assign hs      = (state_q == ISSUE) && op_ok && req_ready;
    assign advance = (state_q == ISSUE) && (hs || !op_ok);
    assign last    = (LEN_W'(idx_q) == len_q - LEN_W'(1));

    // Writes on the launch cycle land before the first FETCH read, so a
    // same-cycle load is seen by the replay.
    trace_ram #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (load_en && idle_like),
        .wr_idx (load_idx),
        .wr_dat ({load_addr, load_op}),
        .rd_en  (state_q == FETCH),
        .rd_idx (idx_q),
        .rd_dat (ram_dat)
    );

    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cache_addr = '0;
        cache_op   = '0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = (len_clamp == '0) ? DONE : FETCH;
            end
            FETCH: begin
                busy    = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                // Malformed ops are never put on the bus, not even their address.
                if (op_ok) begin
                    req_valid  = 1'b1;
                    cache_addr = ent_addr;
                    cache_op   = ent_op;
                end
                if (advance) state_d = last ? DONE : FETCH;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = (len_clamp == '0) ? DONE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            num_issued  <= '0;
            num_reads   <= '0;
            num_writes  <= '0;
            num_skipped <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                idx_q       <= '0;
                len_q       <= len_clamp;
                num_issued  <= '0;
                num_reads   <= '0;
                num_writes  <= '0;
                num_skipped <= '0;
            end else begin
                if (advance && !last) idx_q <= idx_q + 1'b1;
                if (hs) begin
                    if (~&num_issued) num_issued <= num_issued + 1'b1;
                    if (op_rd && (~&num_reads))  num_reads  <= num_reads + 1'b1;
                    if (op_wr && (~&num_writes)) num_writes <= num_writes + 1'b1;
                end
                if (advance && !op_ok && (~&num_skipped)) num_skipped <= num_skipped + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_feeder.sv
// Bench for trace_feeder: scenario tasks against a trace-level reference model.
// Latency: n/a.
// Backpressure: a negedge responder drives req_ready from a per-request stall table.
module tb_trace_feeder;
    localparam int DEPTH  = 100;
    localparam int ADDR_W = 48;
    localparam int OP_W   = 8;
    localparam int CNT_W  = 12;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_en = 1'b0;
    logic [IDX_W-1:0]  load_idx = '0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [OP_W-1:0]   load_op = '0;
    logic [LEN_W-1:0]  trace_len = '0;
    logic              start = 1'b0;
    logic              req_ready = 1'b1;
    logic [ADDR_W-1:0] cache_addr;
    logic [OP_W-1:0]   cache_op;
    logic              req_valid, busy, done;
    logic [CNT_W-1:0]  num_issued, num_reads, num_writes, num_skipped;

    trace_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
        .load_addr(load_addr), .load_op(load_op), .trace_len(trace_len), .start(start),
        .cache_addr(cache_addr), .cache_op(cache_op), .req_valid(req_valid),
        .req_ready(req_ready), .busy(busy), .done(done), .num_issued(num_issued),
        .num_reads(num_reads), .num_writes(num_writes), .num_skipped(num_skipped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference trace table and per-request stall plan (indexed by request ordinal).
    logic [ADDR_W-1:0] m_addr [DEPTH];
    logic [OP_W-1:0]   m_op   [DEPTH];
    int                stall  [DEPTH];

    // Expected replay outcome.
    logic [ADDR_W-1:0] e_addr [$];
    logic [OP_W-1:0]   e_op   [$];
    int e_iss, e_rd, e_wr, e_sk, e_cost;

    // Observed replay.
    logic [ADDR_W-1:0] hs_addr [$];
    logic [OP_W-1:0]   hs_op   [$];
    int hs_cyc [$];
    int done_cyc = -1, first_valid = -1, valid_cnt = 0, unstable = 0, illegal_valid = 0;
    bit presenting = 1'b0;
    int stall_left = 0;
    logic [ADDR_W-1:0] p_addr;
    logic [OP_W-1:0]   p_op;

    // Cache-side responder and observer.
    always @(negedge clk) begin
        if (!reset) presenting = 1'b0;
        if (req_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            if (!presenting) begin
                presenting = 1'b1;
                stall_left = (hs_addr.size() < DEPTH) ? stall[hs_addr.size()] : 0;
                p_addr = cache_addr;
                p_op   = cache_op;
            end else if (cache_addr !== p_addr || cache_op !== p_op) begin
                unstable++;
            end
            if (stall_left > 0) begin
                req_ready = 1'b0;
                stall_left--;
            end else begin
                req_ready = 1'b1;
                hs_addr.push_back(cache_addr);
                hs_op.push_back(cache_op);
                hs_cyc.push_back(cyc);
                presenting = 1'b0;
            end
        end else begin
            if (presenting && reset) unstable++;
            presenting = 1'b0;
            req_ready = 1'b1;
        end
        if (req_valid && (!busy || done)) illegal_valid++;
        if (done && done_cyc < 0) done_cyc = cyc;
    end

    // Trace-level model: a replay visits the first min(len, DEPTH) entries; R/W
    // entries are requested in order and cost 2 cycles plus their stall, others cost 2.
    function automatic void model_run(input int len);
        int l, k;
        l = (len > DEPTH) ? DEPTH : len;
        e_addr.delete(); e_op.delete();
        e_iss = 0; e_rd = 0; e_wr = 0; e_sk = 0; e_cost = 0; k = 0;
        for (int i = 0; i < l; i++) begin
            if (m_op[i] == 8'h52 || m_op[i] == 8'h57) begin
                e_addr.push_back(m_addr[i]);
                e_op.push_back(m_op[i]);
                e_iss++;
                if (m_op[i] == 8'h52) e_rd++; else e_wr++;
                e_cost += 2 + stall[k];
                k++;
            end else begin
                e_sk++;
                e_cost += 2;
            end
        end
    endfunction

    function automatic int seq_diff();
        int n = 0;
        if (hs_addr.size() != e_addr.size()) return 1000 + hs_addr.size();
        for (int i = 0; i < e_addr.size(); i++)
            if (hs_addr[i] !== e_addr[i] || hs_op[i] !== e_op[i]) n++;
        return n;
    endfunction

    function automatic logic [4*CNT_W-1:0] exp_cnt();
        return {CNT_W'(e_iss), CNT_W'(e_rd), CNT_W'(e_wr), CNT_W'(e_sk)};
    endfunction

    function automatic int last_hs();
        return (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -1;
    endfunction

    task automatic load_entry(input int idx, input logic [ADDR_W-1:0] a, input logic [OP_W-1:0] o);
        @(negedge clk);
        load_en = 1'b1; load_idx = IDX_W'(idx); load_addr = a; load_op = o;
        @(posedge clk); #1;
        load_en = 1'b0;
        m_addr[idx] = a; m_op[idx] = o;
    endtask

    task automatic clear_obs();
        hs_addr.delete(); hs_op.delete(); hs_cyc.delete();
        done_cyc = -1; first_valid = -1; valid_cnt = 0;
    endtask

    task automatic start_replay(input int len, output int s);
        @(negedge clk);
        trace_len = LEN_W'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s = cyc;
        clear_obs();
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cyc < 0 && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_valid, busy, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: valid/busy/done=%b want 000", {req_valid, busy, done});
        end
        checks++;
        if ({cache_addr, cache_op} !== '0) begin
            errors++; $display("FAIL reset_bus: addr=%h op=%h want 0", cache_addr, cache_op);
        end
        checks++;
        if ({num_issued, num_reads, num_writes, num_skipped} !== '0) begin
            errors++; $display("FAIL reset_cnt: %0d %0d %0d %0d want 0", num_issued, num_reads, num_writes, num_skipped);
        end
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        int s;
        logic [63:0] r;
        for (int i = 0; i < DEPTH; i++) stall[i] = 0;
        for (int i = 0; i < 20; i++) begin
            r = {$urandom(), $urandom()};
            load_entry(i, (i == 0) ? 48'h7fff493822b8 : r[ADDR_W-1:0],
                       (i % 2 == 0 && i <= 16) ? 8'h57 : 8'h52);
        end
        model_run(20);
        start_replay(20, s);
        wait_done();
        checks++;
        if (first_valid != s + 1) begin
            errors++; $display("FAIL nom_first_valid: cycle %0d want %0d", first_valid - s + 1, 2);
        end
        checks++;
        if (last_hs() != s + 39) begin
            errors++; $display("FAIL nom_last_hs: cycle %0d want %0d", last_hs() - s + 1, 40);
        end
        checks++;
        if (done_cyc != s + 40) begin
            errors++; $display("FAIL nom_done: cycle %0d want %0d", done_cyc - s + 1, 41);
        end
        checks++;
        if ({num_issued, num_reads, num_writes, num_skipped} !== {12'd20, 12'd11, 12'd9, 12'd0}) begin
            errors++; $display("FAIL nom_cnt: %0d/%0d/%0d/%0d want 20/11/9/0", num_issued, num_reads, num_writes, num_skipped);
        end
        checks++;
        if (seq_diff() != 0) begin
            errors++; $display("FAIL nom_seq: diff=%0d got %0d reqs want %0d", seq_diff(), hs_addr.size(), e_addr.size());
        end
        checks++;
        if (hs_addr.size() == 0 || hs_addr[0] !== 48'h7fff493822b8 || hs_op[0] !== 8'h57) begin
            errors++; $display("FAIL nom_first_req: got %0d reqs, want 7fff493822b8/57 first", hs_addr.size());
        end
    endtask

    task automatic test_backpressure();
        int s;
        stall[5] = 3;
        model_run(20);
        start_replay(20, s);
        wait_done();
        checks++;
        if (unstable != 0) begin
            errors++; $display("FAIL bp_stable: %0d unstable cycles want 0", unstable);
        end
        checks++;
        if (done_cyc != s + 43) begin
            errors++; $display("FAIL bp_done: cycle %0d want %0d", done_cyc - s + 1, 44);
        end
        checks++;
        if ({num_issued, num_reads, num_writes, num_skipped} !== {12'd20, 12'd11, 12'd9, 12'd0}) begin
            errors++; $display("FAIL bp_cnt: %0d/%0d/%0d/%0d want 20/11/9/0", num_issued, num_reads, num_writes, num_skipped);
        end
        checks++;
        if (seq_diff() != 0) begin
            errors++; $display("FAIL bp_seq: diff=%0d", seq_diff());
        end
        stall[5] = 0;
    endtask

    task automatic test_invalid_op();
        int s;
        load_entry(2, m_addr[2], 8'h41);
        model_run(4);
        start_replay(4, s);
        wait_done();
        checks++;
        if ({num_issued, num_skipped} !== {12'd3, 12'd1}) begin
            errors++; $display("FAIL inv_cnt: issued=%0d skipped=%0d want 3/1", num_issued, num_skipped);
        end
        checks++;
        if ({num_reads, num_writes} !== {CNT_W'(e_rd), CNT_W'(e_wr)}) begin
            errors++; $display("FAIL inv_rw: %0d/%0d want %0d/%0d", num_reads, num_writes, e_rd, e_wr);
        end
        checks++;
        if (seq_diff() != 0 || valid_cnt != 3) begin
            errors++; $display("FAIL inv_seq: diff=%0d valid_cycles=%0d want 0/3", seq_diff(), valid_cnt);
        end
        checks++;
        if (done_cyc != s + e_cost) begin
            errors++; $display("FAIL inv_done: cycle %0d want %0d", done_cyc - s, e_cost);
        end
        load_entry(2, m_addr[2], 8'h57);
    endtask

    task automatic test_zero_len();
        int s;
        start_replay(0, s);
        wait_done();
        repeat (3) @(negedge clk);
        checks++;
        if (done_cyc != s) begin
            errors++; $display("FAIL zero_done: cycle %0d want %0d", done_cyc, s);
        end
        checks++;
        if (valid_cnt != 0) begin
            errors++; $display("FAIL zero_valid: %0d valid cycles want 0", valid_cnt);
        end
        checks++;
        if ({num_issued, num_reads, num_writes, num_skipped} !== '0) begin
            errors++; $display("FAIL zero_cnt: %0d/%0d/%0d/%0d want 0", num_issued, num_reads, num_writes, num_skipped);
        end
    endtask

    task automatic test_mid_reset();
        int s, n;
        start_replay(20, s);
        n = 0;
        while ((hs_addr.size() < 3 || !req_valid) && n < 200) begin @(negedge clk); n++; end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req_valid, busy, done, cache_addr, cache_op} !== '0 || n >= 200) begin
            errors++; $display("FAIL mrst_out: v/b/d=%b addr=%h op=%h want 0", {req_valid, busy, done}, cache_addr, cache_op);
        end
        checks++;
        if ({num_issued, num_reads, num_writes, num_skipped} !== '0) begin
            errors++; $display("FAIL mrst_cnt: %0d/%0d/%0d/%0d want 0", num_issued, num_reads, num_writes, num_skipped);
        end
        @(negedge clk); #2 reset = 1'b1;
        valid_cnt = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (valid_cnt != 0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mrst_idle: valid_cycles=%0d busy=%b done=%b want 0/0/0", valid_cnt, busy, done);
        end
        model_run(20);
        start_replay(20, s);
        wait_done();
        checks++;
        if (seq_diff() != 0 || {num_issued, num_reads, num_writes} !== {12'd20, 12'd11, 12'd9}) begin
            errors++; $display("FAIL mrst_replay: diff=%0d issued=%0d want 0/20", seq_diff(), num_issued);
        end
    endtask

    task automatic test_guards();
        int s;
        model_run(20);
        start_replay(20, s);
        for (int p = 0; p < 2; p++) begin
            repeat (4 + 7 * p) @(negedge clk);
            load_en = 1'b1; load_idx = '0; load_addr = 48'hdead_beef_0000; load_op = 8'h52;
            start = 1'b1; trace_len = LEN_W'(3);
            @(posedge clk); #1;
            load_en = 1'b0; start = 1'b0;
        end
        wait_done();
        checks++;
        if (seq_diff() != 0 || done_cyc != s + e_cost) begin
            errors++; $display("FAIL guard_run: diff=%0d done=%0d want 0/%0d", seq_diff(), done_cyc - s, e_cost);
        end
        start_replay(20, s);
        wait_done();
        checks++;
        if (seq_diff() != 0 || {num_issued, num_reads, num_writes, num_skipped} !== exp_cnt()) begin
            errors++; $display("FAIL guard_rerun: diff=%0d issued=%0d want 0/%0d", seq_diff(), num_issued, e_iss);
        end
    endtask

    task automatic test_load_start();
        @(negedge clk);
        load_en = 1'b1; load_idx = '0; load_addr = 48'h1234_5678_9abc; load_op = 8'h52;
        start = 1'b1; trace_len = LEN_W'(2);
        @(posedge clk); #1;
        load_en = 1'b0; start = 1'b0;
        clear_obs();
        m_addr[0] = 48'h1234_5678_9abc; m_op[0] = 8'h52;
        model_run(2);
        wait_done();
        checks++;
        if (seq_diff() != 0 || {num_issued, num_reads, num_writes, num_skipped} !== exp_cnt()) begin
            errors++; $display("FAIL load_start: diff=%0d first=%h want 123456789abc", seq_diff(),
                               (hs_addr.size() > 0) ? hs_addr[0] : '0);
        end
    endtask

    task automatic test_random();
        int s, len, r;
        logic [63:0] a;
        for (int it = 0; it < 2; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = {$urandom(), $urandom()};
                r = $urandom_range(0, 9);
                load_entry(i, a[ADDR_W-1:0], (r < 4) ? 8'h52 : (r < 8) ? 8'h57 : OP_W'($urandom_range(0, 255)));
                stall[i] = $urandom_range(0, 2);
            end
            len = (it == 0) ? $urandom_range(1, 99) : 127;
            unstable = 0;
            model_run(len);
            start_replay(len, s);
            wait_done();
            checks++;
            if (seq_diff() != 0) begin
                errors++; $display("FAIL rand_seq[%0d]: len=%0d diff=%0d", it, len, seq_diff());
            end
            checks++;
            if ({num_issued, num_reads, num_writes, num_skipped} !== exp_cnt()) begin
                errors++; $display("FAIL rand_cnt[%0d]: %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", it,
                                   num_issued, num_reads, num_writes, num_skipped, e_iss, e_rd, e_wr, e_sk);
            end
            checks++;
            if (done_cyc != s + e_cost || unstable != 0) begin
                errors++; $display("FAIL rand_timing[%0d]: done=%0d unstable=%0d want %0d/0", it, done_cyc - s, unstable, e_cost);
            end
        end
        checks++;
        if (illegal_valid != 0) begin
            errors++; $display("FAIL valid_outside_busy: %0d cycles want 0", illegal_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            stall[i] = 0; m_addr[i] = '0; m_op[i] = '0;
        end
        test_reset();
        test_nominal();
        test_backpressure();
        test_invalid_op();
        test_zero_len();
        test_mid_reset();
        test_guards();
        test_load_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
